// File: rtl/counter_capture.sv
// counter_capture: timestamps rising edges of event_in with the counter value into a FWFT FIFO.
// Latency: capture visible one cycle after the detecting edge (+2 cycles when COUNTER_CAPTURE_SYNC_EN is defined).
// Backpressure: head held until cap_ready; captures arriving while full (and not popping) are dropped and flagged sticky.
module counter_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         value,
    input  logic                     event_in,
    output logic [WIDTH-1:0]         cap_data,
    output logic                     cap_valid,
    input  logic                     cap_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic             ev_s;
    logic             ev_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push, pop, full, wr_en, drop;

`ifdef COUNTER_CAPTURE_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer so event_in may come from an unrelated clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= event_in;
            sync2_q <= sync1_q;
        end
    end

    assign ev_s = sync2_q;
`else
    assign ev_s = event_in;
`endif

    // Previous event level; keeps tracking during reset so a level held across release is not an edge
    always_ff @(posedge clk) begin
        ev_q <= ev_s;
    end

    // Push/pop decisions and next-state for pointers, occupancy and sticky overflow
    always_comb begin
        push  = ev_s & ~ev_q;
        pop   = (level_q != '0) & cap_ready;
        full  = (level_q == FULL_LVL);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;

        if (wr_en && !pop)      level_d = level_q + LVL_ONE;
        else if (!wr_en && pop) level_d = level_q - LVL_ONE;

        // Set beats clear so a drop is never hidden by a coincident clear
        if (drop)           ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Timestamp storage; contents are don't-care after reset since level gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= value;
    end

    assign cap_data  = mem_q[rd_ptr_q];
    assign cap_valid = (level_q != '0);
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_counter_capture.sv
// Bench for counter_capture: free-running counter model, directed event stimulus,
// expected timestamps queued at stimulus time and checked by a monitor on every pop.
module tb_counter_capture;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef COUNTER_CAPTURE_SYNC_EN
    localparam int SHIFT = 2;
`else
    localparam int SHIFT = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] value = '0;
    logic             event_in = 1'b1;
    logic [WIDTH-1:0] cap_data;
    logic             cap_valid;
    logic             cap_ready = 1'b0;
    logic [2:0]       level;
    logic             overflow;
    logic             clear_ovf = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q [$];

    counter_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .event_in  (event_in),
        .cap_data  (cap_data),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    // Free-running 8-bit counter feeding value, updated just after each rising edge
    always begin
        @(posedge clk);
        #1 value = value + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_value(input logic [7:0] v);
        int n = 0;
        while (value != v && n < 300) begin
            step();
            n++;
        end
        if (value != v) chk("wait_value", 32'(value), 32'(v));
    endtask

    // One-cycle event pulse while the counter shows v; queue the expected timestamp if it should land
    task automatic pulse_at(input logic [7:0] v, input bit expect_push);
        wait_value(v);
        event_in = 1'b1;
        step();
        event_in = 1'b0;
        if (expect_push) exp_q.push_back(8'(v + SHIFT));
    endtask

    // Event timed so its detecting edge sees counter value v, with ready/clear asserted on that same edge
    task automatic race_at(input logic [7:0] v, input bit rdy, input bit clr);
        wait_value(8'(v - SHIFT));
        event_in = 1'b1;
        repeat (SHIFT) begin
            step();
            event_in = 1'b0;
        end
        cap_ready = rdy;
        clear_ovf = clr;
        step();
        event_in  = 1'b0;
        cap_ready = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic wait_sync();
        repeat (SHIFT) step();
    endtask

    task automatic drain(input int n);
        cap_ready = 1'b1;
        repeat (n) step();
        cap_ready = 1'b0;
    endtask

    task automatic do_reset();
        event_in  = 1'b0;
        cap_ready = 1'b0;
        clear_ovf = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset     = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        // Scoreboard monitor: every accepted head is compared against the oldest expected timestamp
        fork
            forever begin
                @(negedge clk);
                if (!reset && cap_valid && cap_ready) begin
                    if (exp_q.size() == 0) chk("sb_unexpected_pop", 32'(cap_data), 32'hFFFF_FFFF);
                    else                   chk("sb_data", 32'(cap_data), 32'(exp_q.pop_front()));
                end
            end
        join_none

        // Reset then idle with event held high through release
        step();
        step();
        chk("rst_valid", 32'(cap_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;
        repeat (5) step();
        // Synchronizer flops clear to 0, so the synchronised build sees the held level rise after release
        chk("idle_level", 32'(level), (SHIFT != 0) ? 1 : 0);
        chk("idle_valid", 32'(cap_valid), (SHIFT != 0) ? 1 : 0);
        chk("idle_ovf", 32'(overflow), 0);
        do_reset();
        chk("reset2_level", 32'(level), 0);

        // Single capture
        pulse_at(8'h23, 1'b1);
        wait_sync();
        chk("single_level", 32'(level), 1);
        chk("single_valid", 32'(cap_valid), 1);
        chk("single_data", 32'(cap_data), 32'(8'h23 + SHIFT));
        drain(1);
        chk("single_pop_valid", 32'(cap_valid), 0);
        chk("single_pop_level", 32'(level), 0);

        // Fill and overflow
        pulse_at(8'h10, 1'b1);
        pulse_at(8'h14, 1'b1);
        pulse_at(8'h18, 1'b1);
        pulse_at(8'h1C, 1'b1);
        pulse_at(8'h20, 1'b0);
        wait_sync();
        chk("fill_level", 32'(level), 4);
        chk("fill_ovf", 32'(overflow), 1);
        drain(4);
        chk("fill_drained_level", 32'(level), 0);
        chk("fill_drained_valid", 32'(cap_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Full with a simultaneous pop: new entry takes the freed slot
        pulse_at(8'h10, 1'b1);
        pulse_at(8'h14, 1'b1);
        pulse_at(8'h18, 1'b1);
        pulse_at(8'h1C, 1'b1);
        wait_sync();
        chk("full_level", 32'(level), 4);
        exp_q.push_back(8'h30);
        race_at(8'h30, 1'b1, 1'b0);
        chk("pushpop_level", 32'(level), 4);
        chk("pushpop_ovf", 32'(overflow), 0);
        drain(4);
        chk("pushpop_drained", 32'(level), 0);

        // Overflow set wins over a coincident clear
        pulse_at(8'h40, 1'b1);
        pulse_at(8'h44, 1'b1);
        pulse_at(8'h48, 1'b1);
        pulse_at(8'h4C, 1'b1);
        wait_sync();
        chk("race_pre_level", 32'(level), 4);
        chk("race_pre_ovf", 32'(overflow), 0);
        race_at(8'h50, 1'b0, 1'b1);
        chk("race_ovf_set", 32'(overflow), 1);
        chk("race_level", 32'(level), 4);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("race_ovf_clr", 32'(overflow), 0);

        // Reset mid-operation discards pending entries
        drain(1);
        chk("mid_level3", 32'(level), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_valid", 32'(cap_valid), 0);
        pulse_at(8'h55, 1'b1);
        wait_sync();
        chk("post_rst_level", 32'(level), 1);
        chk("post_rst_data", 32'(cap_data), 32'(8'h55 + SHIFT));
        drain(1);
        chk("post_rst_drained", 32'(level), 0);

        step();
        chk("sb_leftover", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
